maxpool2d: RTL and testbench
============================

# maxpool2d

Downstream pooling stage for `conv2d`. After `conv2d` asserts `done`, this block reads the conv output memory (NCHW, one element per address) and computes a max over each POOL_SIZE×POOL_SIZE window. An optional ReLU is applied to each result, which is then written to a pooled output memory. The memory-port style and the start/done/valid protocol are the same as `conv2d`, so the two blocks chain through a shared buffer under a top-level sequencer.

## Interface
- `BATCH_SIZE`, default 1: number of images.
- `CHANNELS`, default 1: channels. Equals conv2d OUT_CHANNELS.
- `IN_HEIGHT`, default 2: input rows. Equals conv2d OUT_HEIGHT.
- `IN_WIDTH`, default 2: input columns. Equals conv2d OUT_WIDTH.
- `POOL_SIZE`, default 2: window edge.
- `STRIDE`, default 2: window step.
- `RELU_EN`, default 0: when 1, negative results are clamped to 0.
- `DATA_WIDTH`, default 8: element width, two's-complement signed.
- `ADDR_WIDTH`, default 16: memory address width.
- Derived: `OUT_HEIGHT = (IN_HEIGHT-POOL_SIZE)/STRIDE+1`; `OUT_WIDTH` is analogous.

Ports:
- `clk` in 1: the only clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin one full pass. Sampled only in IDLE or DONE.
- `done` out 1: level-high when the pass is complete.
- `valid` out 1: one-cycle pulse, coincident with each output write.
- `input_addr` out ADDR_WIDTH: read address.
- `input_data` in DATA_WIDTH: read data. Combinational, valid in the same cycle as `input_addr`/`input_en`.
- `input_en` out 1: read enable.
- `output_addr` out ADDR_WIDTH: write address.
- `output_data` out DATA_WIDTH: write data.
- `output_we` out 1: write enable.
- `output_en` out 1: output memory enable.

## Operation
- FSM states: IDLE → READ → WRITE → (READ | DONE). DONE → READ on `start`.
- **IDLE / DONE:** when `start`=1 at a posedge, all counters clear and the FSM enters READ. `start` is ignored in READ and WRITE.
- **READ:**
  - Takes POOL_SIZE² cycles, one element per cycle, scanning the window row-major (ky outer, kx inner).
  - Read address: `input_addr = ((b*CHANNELS+c)*IN_HEIGHT + oy*STRIDE+ky)*IN_WIDTH + ox*STRIDE+kx`.
  - `input_en`=1 throughout READ.
  - The first element of the window loads the running max. Each later element replaces it if larger under a signed compare. The running max never starts at 0.
- **WRITE:**
  - Lasts exactly one cycle.
  - `output_en`=`output_we`=`valid`=1.
  - `output_addr = ((b*CHANNELS+c)*OUT_HEIGHT+oy)*OUT_WIDTH+ox`.
  - `output_data` = running max, or 0 if RELU_EN=1 and the max is negative.
- **Window advance:** ox is the innermost loop, then oy, c, b. After the last window's WRITE, the FSM goes to DONE.
- No arithmetic widening; comparison is at DATA_WIDTH, signed.
- Element addresses at or above the memory size are never produced.

## Timing
- **Reset values:**
  - `done`, `valid`, `input_en`, `output_en`, `output_we` = 0.
  - `input_addr`, `output_addr`, `output_data` = 0.
  - FSM = IDLE; all counters = 0.
- **Reset mid-pass:** forces reset values immediately (asynchronous). Partially written output is left as-is. The next pass requires a new `start`.
- **Start:** the `start` posedge is followed by the first READ cycle, with `input_addr` for window (0,0) driven in that cycle.
- **Per-output cost:** POOL_SIZE²+1 cycles.
- **Total pass:** N·(POOL_SIZE²+1) cycles from the first READ to the last WRITE, where N = BATCH·CHANNELS·OUT_HEIGHT·OUT_WIDTH. `done` rises on the next cycle.
- **`done`:** holds high until the cycle after a new `start` is accepted, then drops.
- **Outputs:** registered; no combinational path from `input_data` to any output.
- `output_data` and `output_addr` hold their values outside WRITE cycles. Only the enables return to 0.

## Structure
- A shared package `cnn_pkg` holds:
  - The state enum (IDLE, READ, WRITE, DONE).
  - The NCHW address-compute function, reused by `conv2d` and `maxpool2d`.
  - The output-dimension formula.
- One natural sub-module is `window_addr_gen`. It holds the nested counters (b, c, oy, ox, ky, kx) and emits the read address, write address, `last_in_window` and `last_window`.
- The FSM, running-max register and ReLU stay in the top level.

## Test plan
- **Basic pooling:** 1×1×4×4 input with values 0..15, P=2, S=2, RELU_EN=0. Required outputs: [5, 7, 13, 15]. `valid` pulses 4 times, `done` rises exactly 21 cycles after `start`.
- **Signed and ReLU:** all inputs 0xFD (−3), 2×2 input. RELU_EN=0 must give 0xFD. RELU_EN=1 must give 0x00. Mixed window {0x80, 0xFF, 0x7F, 0x01} must give 0x7F.
- **Multi-channel:** CHANNELS=2, 4×4 per channel, ch0 = 0..15, ch1 = 15..0. Required outputs: [5, 7, 13, 15, 15, 13, 7, 5] at addresses 0..7.
- **Overlap:** 3×3 input, P=2, S=1, values 1..9. Required outputs: [5, 6, 8, 9].
- **Protocol:** `start` pulsed during READ is ignored and the output is unchanged. `start` pulsed in DONE reruns the pass with identical results. `rst_n` low in mid-pass returns all outputs to 0 asynchronously; a subsequent `start` completes correctly.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer blocks: sequencer state encoding,
// NCHW flat address computation and the pooled/convolved output-size formula.
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Flat address of element (n, c, h, w) in an NCHW tensor of shape (., ch, hh, ww).
    function automatic int unsigned nchw_addr(
        input int unsigned n,
        input int unsigned c,
        input int unsigned h,
        input int unsigned w,
        input int unsigned ch,
        input int unsigned hh,
        input int unsigned ww
    );
        return ((n * ch + c) * hh + h) * ww + w;
    endfunction

    // Number of window positions along one axis.
    function automatic int out_dim(input int in_size, input int win, input int step);
        return (in_size - win) / step + 1;
    endfunction

endpackage

// File: rtl/maxpool2d_window_addr_gen.sv
// Nested window counters (b, c, oy, ox, ky, kx) for the pooling scan.
// The read address is registered from the next counter values so it is
// valid in the same cycle the counters point at that element.
module window_addr_gen
    import cnn_pkg::*;
#(
    parameter int BATCH_SIZE = 1,
    parameter int CHANNELS   = 1,
    parameter int IN_HEIGHT  = 2,
    parameter int IN_WIDTH   = 2,
    parameter int POOL_SIZE  = 2,
    parameter int STRIDE     = 2,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  elem_step,
    input  logic                  win_step,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  first_in_window,
    output logic                  last_in_window,
    output logic                  last_window
);

    localparam int unsigned NB = BATCH_SIZE;
    localparam int unsigned NC = CHANNELS;
    localparam int unsigned IH = IN_HEIGHT;
    localparam int unsigned IW = IN_WIDTH;
    localparam int unsigned P  = POOL_SIZE;
    localparam int unsigned S  = STRIDE;
    localparam int unsigned OH = out_dim(IN_HEIGHT, POOL_SIZE, STRIDE);
    localparam int unsigned OW = out_dim(IN_WIDTH, POOL_SIZE, STRIDE);

    int unsigned b, c, oy, ox, ky, kx;
    int unsigned nb, nc, noy, nox, nky, nkx;

    // Next-count logic: kx innermost within a window, then ox, oy, c, b across windows.
    always_comb begin
        nb  = b;
        nc  = c;
        noy = oy;
        nox = ox;
        nky = ky;
        nkx = kx;
        if (clear) begin
            nb  = 0;
            nc  = 0;
            noy = 0;
            nox = 0;
            nky = 0;
            nkx = 0;
        end else if (elem_step) begin
            if (kx == P - 1) begin
                nkx = 0;
                nky = ky + 1;
            end else begin
                nkx = kx + 1;
            end
        end else if (win_step) begin
            nky = 0;
            nkx = 0;
            if (ox == OW - 1) begin
                nox = 0;
                if (oy == OH - 1) begin
                    noy = 0;
                    if (c == NC - 1) begin
                        nc = 0;
                        nb = (b == NB - 1) ? 0 : b + 1;
                    end else begin
                        nc = c + 1;
                    end
                end else begin
                    noy = oy + 1;
                end
            end else begin
                nox = ox + 1;
            end
        end
    end

    // Counter and read-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b       <= 0;
            c       <= 0;
            oy      <= 0;
            ox      <= 0;
            ky      <= 0;
            kx      <= 0;
            rd_addr <= '0;
        end else begin
            b       <= nb;
            c       <= nc;
            oy      <= noy;
            ox      <= nox;
            ky      <= nky;
            kx      <= nkx;
            rd_addr <= ADDR_WIDTH'(nchw_addr(nb, nc, noy * S + nky, nox * S + nkx, NC, IH, IW));
        end
    end

    assign wr_addr         = ADDR_WIDTH'(nchw_addr(b, c, oy, ox, NC, OH, OW));
    assign first_in_window = (ky == 0) && (kx == 0);
    assign last_in_window  = (ky == P - 1) && (kx == P - 1);
    assign last_window     = (b == NB - 1) && (c == NC - 1) && (oy == OH - 1) && (ox == OW - 1);

endmodule

// File: rtl/maxpool2d.sv
// Max-pooling layer: scans each POOL_SIZE x POOL_SIZE window of an NCHW
// tensor, keeps a signed running max, optionally applies ReLU and writes
// one result per window. Same start/done/valid handshake as conv2d.
module maxpool2d
    import cnn_pkg::*;
#(
    parameter int BATCH_SIZE = 1,
    parameter int CHANNELS   = 1,
    parameter int IN_HEIGHT  = 2,
    parameter int IN_WIDTH   = 2,
    parameter int POOL_SIZE  = 2,
    parameter int STRIDE     = 2,
    parameter int RELU_EN    = 0,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  done,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] input_addr,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  input_en,
    output logic [ADDR_WIDTH-1:0] output_addr,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_we,
    output logic                  output_en
);

    state_t                        state;
    logic signed [DATA_WIDTH-1:0]  run_max;
    logic signed [DATA_WIDTH-1:0]  sample;
    logic signed [DATA_WIDTH-1:0]  cand;
    logic                          clear, elem_step, win_step;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic                          first_in_window, last_in_window, last_window;

    function automatic logic signed [DATA_WIDTH-1:0] relu(input logic signed [DATA_WIDTH-1:0] x);
        return (RELU_EN != 0 && x < 0) ? '0 : x;
    endfunction

    window_addr_gen #(
        .BATCH_SIZE (BATCH_SIZE),
        .CHANNELS   (CHANNELS),
        .IN_HEIGHT  (IN_HEIGHT),
        .IN_WIDTH   (IN_WIDTH),
        .POOL_SIZE  (POOL_SIZE),
        .STRIDE     (STRIDE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .elem_step       (elem_step),
        .win_step        (win_step),
        .rd_addr         (input_addr),
        .wr_addr         (wr_addr),
        .first_in_window (first_in_window),
        .last_in_window  (last_in_window),
        .last_window     (last_window)
    );

    // Counter strobes and the max candidate including the element read this cycle.
    always_comb begin
        clear     = ((state == ST_IDLE) || (state == ST_DONE)) && start;
        elem_step = (state == ST_READ) && !last_in_window;
        win_step  = (state == ST_WRITE);
        sample    = signed'(input_data);
        cand      = (first_in_window || sample > run_max) ? sample : run_max;
    end

    // Running max accumulates over the READ cycles of one window.
    always_ff @(posedge clk) begin
        if (state == ST_READ) begin
            run_max <= cand;
        end
    end

    // Sequencer with registered memory-port and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            done        <= 1'b0;
            valid       <= 1'b0;
            input_en    <= 1'b0;
            output_en   <= 1'b0;
            output_we   <= 1'b0;
            output_addr <= '0;
            output_data <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_READ;
                        done     <= 1'b0;
                        input_en <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (last_in_window) begin
                        state       <= ST_WRITE;
                        input_en    <= 1'b0;
                        output_en   <= 1'b1;
                        output_we   <= 1'b1;
                        valid       <= 1'b1;
                        output_addr <= wr_addr;
                        output_data <= relu(cand);
                    end
                end
                ST_WRITE: begin
                    output_en <= 1'b0;
                    output_we <= 1'b0;
                    valid     <= 1'b0;
                    if (last_window) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= ST_READ;
                        input_en <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool2d.sv
// Bench for maxpool2d: five configurations share one clock; each has its own
// input memory, expected-write queue and a monitor that checks every write.
module tb_maxpool2d;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start     [5];
    logic        done_s    [5];
    logic        valid_s   [5];
    logic        in_en     [5];
    logic        out_en    [5];
    logic        out_we    [5];
    logic [15:0] in_addr   [5];
    logic [15:0] out_addr  [5];
    logic [7:0]  in_data   [5];
    logic [7:0]  out_data  [5];
    logic [7:0]  imem      [5][32];
    exp_t        exp_q     [5][$];
    int          vcnt      [5];
    int          checks;
    int          errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 5; i++) in_data[i] = imem[i][in_addr[i][4:0]];
    end

    // 0: basic 1x1x4x4, P2 S2
    maxpool2d #(.BATCH_SIZE(1), .CHANNELS(1), .IN_HEIGHT(4), .IN_WIDTH(4), .POOL_SIZE(2),
                .STRIDE(2), .RELU_EN(0), .DATA_WIDTH(8), .ADDR_WIDTH(16)) u_basic (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .done(done_s[0]), .valid(valid_s[0]),
        .input_addr(in_addr[0]), .input_data(in_data[0]), .input_en(in_en[0]),
        .output_addr(out_addr[0]), .output_data(out_data[0]), .output_we(out_we[0]), .output_en(out_en[0]));

    // 1: two channels 4x4
    maxpool2d #(.BATCH_SIZE(1), .CHANNELS(2), .IN_HEIGHT(4), .IN_WIDTH(4), .POOL_SIZE(2),
                .STRIDE(2), .RELU_EN(0), .DATA_WIDTH(8), .ADDR_WIDTH(16)) u_mc (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .done(done_s[1]), .valid(valid_s[1]),
        .input_addr(in_addr[1]), .input_data(in_data[1]), .input_en(in_en[1]),
        .output_addr(out_addr[1]), .output_data(out_data[1]), .output_we(out_we[1]), .output_en(out_en[1]));

    // 2: overlapping windows 3x3, P2 S1
    maxpool2d #(.BATCH_SIZE(1), .CHANNELS(1), .IN_HEIGHT(3), .IN_WIDTH(3), .POOL_SIZE(2),
                .STRIDE(1), .RELU_EN(0), .DATA_WIDTH(8), .ADDR_WIDTH(16)) u_ov (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .done(done_s[2]), .valid(valid_s[2]),
        .input_addr(in_addr[2]), .input_data(in_data[2]), .input_en(in_en[2]),
        .output_addr(out_addr[2]), .output_data(out_data[2]), .output_we(out_we[2]), .output_en(out_en[2]));

    // 3: signed 2x2, no ReLU
    maxpool2d #(.BATCH_SIZE(1), .CHANNELS(1), .IN_HEIGHT(2), .IN_WIDTH(2), .POOL_SIZE(2),
                .STRIDE(2), .RELU_EN(0), .DATA_WIDTH(8), .ADDR_WIDTH(16)) u_sg0 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .done(done_s[3]), .valid(valid_s[3]),
        .input_addr(in_addr[3]), .input_data(in_data[3]), .input_en(in_en[3]),
        .output_addr(out_addr[3]), .output_data(out_data[3]), .output_we(out_we[3]), .output_en(out_en[3]));

    // 4: signed 2x2 with ReLU
    maxpool2d #(.BATCH_SIZE(1), .CHANNELS(1), .IN_HEIGHT(2), .IN_WIDTH(2), .POOL_SIZE(2),
                .STRIDE(2), .RELU_EN(1), .DATA_WIDTH(8), .ADDR_WIDTH(16)) u_sg1 (
        .clk(clk), .rst_n(rst_n), .start(start[4]), .done(done_s[4]), .valid(valid_s[4]),
        .input_addr(in_addr[4]), .input_data(in_data[4]), .input_en(in_en[4]),
        .output_addr(out_addr[4]), .output_data(out_data[4]), .output_we(out_we[4]), .output_en(out_en[4]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int i, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q[i].push_back(e);
    endtask

    function automatic logic [44:0] all_outs(input int i);
        return {done_s[i], valid_s[i], in_en[i], out_en[i], out_we[i], in_addr[i], out_addr[i], out_data[i]};
    endfunction

    // Monitor: every write strobe is checked against the head of that instance's queue.
    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (valid_s[i]) begin
                vcnt[i]++;
                if (exp_q[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write[%0d]: got addr %0d data 0x%0h, required no write",
                             i, out_addr[i], out_data[i]);
                end else begin
                    exp_t e;
                    e = exp_q[i].pop_front();
                    chk($sformatf("write[%0d]{we,en,addr,data}", i),
                        {out_we[i], out_en[i], out_addr[i], out_data[i]}, {2'b11, e.a, e.d});
                end
            end
        end
    end

    // One pass: pulse start, optionally pulse start again mid-pass, wait for done.
    task automatic run_pass(input int i, input int exp_cyc, input int exp_wr, input int glitch);
        int n;
        vcnt[i] = 0;
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        n = 1;
        while (!done_s[i] && n < 500) begin
            start[i] = (glitch != 0 && n == glitch);
            @(negedge clk);
            n++;
        end
        start[i] = 1'b0;
        chk($sformatf("done_latency[%0d]", i), n, exp_cyc);
        chk($sformatf("pending_writes[%0d]", i), exp_q[i].size(), 0);
        chk($sformatf("write_count[%0d]", i), vcnt[i], exp_wr);
    endtask

    task automatic push_basic();
        push(0, 16'd0, 8'd5);
        push(0, 16'd1, 8'd7);
        push(0, 16'd2, 8'd13);
        push(0, 16'd3, 8'd15);
    endtask

    task automatic load_signed(input logic [7:0] v0, input logic [7:0] v1,
                               input logic [7:0] v2, input logic [7:0] v3);
        for (int i = 3; i < 5; i++) begin
            imem[i][0] = v0;
            imem[i][1] = v1;
            imem[i][2] = v2;
            imem[i][3] = v3;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start[i] = 1'b0;
            vcnt[i]  = 0;
            for (int k = 0; k < 32; k++) imem[i][k] = 8'h00;
        end
        for (int k = 0; k < 16; k++) begin
            imem[0][k]      = 8'(k);
            imem[1][k]      = 8'(k);
            imem[1][16 + k] = 8'(15 - k);
        end
        for (int k = 0; k < 9; k++) imem[2][k] = 8'(k + 1);
        load_signed(8'hFD, 8'hFD, 8'hFD, 8'hFD);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) chk($sformatf("reset_outputs[%0d]", i), all_outs(i), 45'd0);
        rst_n = 1'b1;

        // Basic pooling, then the written value/address must hold in DONE
        push_basic();
        run_pass(0, 21, 4, 0);
        chk("hold_after_pass{done,we,en,addr,data}",
            {done_s[0], out_we[0], out_en[0], out_addr[0], out_data[0]}, {3'b100, 16'd3, 8'd15});

        // Multi-channel
        push(1, 16'd0, 8'd5);  push(1, 16'd1, 8'd7);  push(1, 16'd2, 8'd13); push(1, 16'd3, 8'd15);
        push(1, 16'd4, 8'd15); push(1, 16'd5, 8'd13); push(1, 16'd6, 8'd7);  push(1, 16'd7, 8'd5);
        run_pass(1, 41, 8, 0);

        // Overlapping windows
        push(2, 16'd0, 8'd5); push(2, 16'd1, 8'd6); push(2, 16'd2, 8'd8); push(2, 16'd3, 8'd9);
        run_pass(2, 21, 4, 0);

        // All -3: negative max survives without ReLU, clamps with ReLU
        push(3, 16'd0, 8'hFD);
        run_pass(3, 6, 1, 0);
        push(4, 16'd0, 8'h00);
        run_pass(4, 6, 1, 0);

        // Mixed extremes
        load_signed(8'h80, 8'hFF, 8'h7F, 8'h01);
        push(3, 16'd0, 8'h7F);
        run_pass(3, 6, 1, 0);
        push(4, 16'd0, 8'h7F);
        run_pass(4, 6, 1, 0);

        // All negative, distinct: max is -1, never a stale 0
        load_signed(8'h80, 8'hFE, 8'h81, 8'hFF);
        push(3, 16'd0, 8'hFF);
        run_pass(3, 6, 1, 0);
        push(4, 16'd0, 8'h00);
        run_pass(4, 6, 1, 0);

        // start during READ is ignored
        push_basic();
        run_pass(0, 21, 4, 3);

        // start from DONE reruns identically
        push_basic();
        run_pass(0, 21, 4, 0);

        // Asynchronous reset in the middle of a pass
        push_basic();
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_pass_busy{in_en,data}", {in_en[0], out_data[0]}, {1'b1, 8'd5});
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs[0]", all_outs(0), 45'd0);
        exp_q[0].delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("stays_idle_after_reset{done,in_en}", {done_s[0], in_en[0]}, 2'b00);

        push_basic();
        run_pass(0, 21, 4, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
